// File: rtl/cpu6502_bus_arb.sv
// Bus arbiter sharing the system bus between the 6502 core, video fetch (high
// priority) and DMA (low priority); drives the core's RDY and the bus mux select.
module cpu6502_bus_arb #(
    parameter int unsigned DMA_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_we,
    input  logic       vid_req,
    input  logic       dma_req,
    output logic       rdy,
    output logic       vid_gnt,
    output logic       dma_gnt,
    output logic [1:0] owner
);

    typedef enum logic [2:0] {
        ST_CPU     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_VID     = 3'd2,
        ST_DMA     = 3'd3,
        ST_HANDOFF = 3'd4
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(DMA_MAX - 32'd1);

    state_t     state_r, state_s;
    logic       tgt_vid_r, tgt_vid_s;
    logic       cool_r, cool_s;
    logic [7:0] burst_r, burst_s;
    logic [1:0] owner_s;

    // Next-state, pending target, burst counter and cooldown logic.
    // The cooldown is the single forced CPU cycle after a DMA burst; the request
    // is honoured again at the edge closing that cycle.
    always_comb begin
        state_s   = state_r;
        tgt_vid_s = tgt_vid_r;
        cool_s    = cool_r;
        burst_s   = burst_r;
        case (state_r)
            ST_CPU: begin
                cool_s = 1'b0;
                if (vid_req || dma_req) begin
                    state_s   = ST_DRAIN;
                    tgt_vid_s = vid_req;
                end else begin
                    state_s = ST_CPU;
                end
            end
            ST_DRAIN: begin
                if (!vid_req && !dma_req) begin
                    state_s = ST_CPU;
                end else begin
                    // video always takes over a pending DMA target
                    tgt_vid_s = vid_req;
                    if (!cpu_we) begin
                        state_s = vid_req ? ST_VID : ST_DMA;
                        burst_s = 8'd0;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
            end
            ST_VID: begin
                if (!vid_req) begin
                    if (dma_req && !cool_r) begin
                        state_s   = ST_HANDOFF;
                        tgt_vid_s = 1'b0;
                    end else begin
                        state_s = ST_CPU;
                    end
                end else begin
                    state_s = ST_VID;
                end
            end
            ST_DMA: begin
                if (vid_req) begin
                    state_s   = ST_HANDOFF;
                    tgt_vid_s = 1'b1;
                end else if (!dma_req) begin
                    state_s = ST_CPU;
                end else if (burst_r == BURST_LAST) begin
                    state_s = ST_CPU;
                    cool_s  = 1'b1;
                end else begin
                    burst_s = burst_r + 8'd1;
                end
            end
            ST_HANDOFF: begin
                if (tgt_vid_r) begin
                    state_s = vid_req ? ST_VID : ST_CPU;
                end else if (dma_req) begin
                    state_s = ST_DMA;
                    burst_s = 8'd0;
                end else begin
                    state_s = ST_CPU;
                end
            end
            default: begin
                state_s = ST_CPU;
            end
        endcase
    end

    // Bus mux select decoded from the next state.
    always_comb begin
        owner_s = 2'd3;
        case (state_s)
            ST_CPU:  owner_s = 2'd0;
            ST_VID:  owner_s = 2'd1;
            ST_DMA:  owner_s = 2'd2;
            default: owner_s = 2'd3;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_CPU;
            tgt_vid_r <= 1'b0;
            cool_r    <= 1'b0;
            burst_r   <= 8'd0;
            rdy       <= 1'b1;
            vid_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            owner     <= 2'd0;
        end else begin
            state_r   <= state_s;
            tgt_vid_r <= tgt_vid_s;
            cool_r    <= cool_s;
            burst_r   <= burst_s;
            rdy       <= (state_s == ST_CPU);
            vid_gnt   <= (state_s == ST_VID);
            dma_gnt   <= (state_s == ST_DMA);
            owner     <= owner_s;
        end
    end

endmodule
